rsa_job_arbiter: RTL

RSA_JOB_ARBITER -- requirements
Module: rsa_job_arbiter

---
 rtl/rsa_job_arbiter.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/rsa_job_arbiter.sv
// Two-requester front end for a modular-exponentiation core: arbitrates jobs,
// sequences core restart/enable, and returns results or timeout aborts.
module rsa_job_arbiter #(
  parameter int unsigned OPW  = 8,
  parameter int unsigned EXPW = 6,
  parameter int unsigned TMO  = 200
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic            req_0,
  input  logic            req_1,
  input  logic [OPW-1:0]  m_0,
  input  logic [OPW-1:0]  n_0,
  input  logic [EXPW-1:0] e_0,
  input  logic [OPW-1:0]  m_1,
  input  logic [OPW-1:0]  n_1,
  input  logic [EXPW-1:0] e_1,
  output logic            acc_0,
  output logic            acc_1,
  output logic            rvalid_0,
  output logic            rvalid_1,
  output logic [OPW-1:0]  rdata_0,
  output logic [OPW-1:0]  rdata_1,
  output logic            rerr_0,
  output logic            rerr_1,
  input  logic            rready_0,
  input  logic            rready_1,
  output logic            core_rstb,
  output logic            core_en,
  output logic [OPW-1:0]  core_m,
  output logic [OPW-1:0]  core_n,
  output logic [EXPW-1:0] core_e,
  input  logic            core_eoc,
  input  logic [OPW-1:0]  core_res,
  output logic            busy,
  output logic            owner
);
  localparam int unsigned CW = $clog2(TMO) + 1;

  typedef enum logic [1:0] {IDLE, SETUP, RUN, DONE} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            last_q, last_d, owner_q, owner_d, rstb_q;
  logic [1:0]      acc_q, acc_d, rvalid_q, rvalid_d, rerr_q, rerr_d;
  logic [OPW-1:0]  rdata0_q, rdata0_d, rdata1_q, rdata1_d;
  logic [OPW-1:0]  cm_q, cm_d, cn_q, cn_d;
  logic [EXPW-1:0] ce_q, ce_d;
  logic            win, rready_own, tmo_hit;

  // Tie goes to the requester that was not served last.
  assign win        = (req_0 & req_1) ? ~last_q : req_1;
  assign rready_own = owner_q ? rready_1 : rready_0;
  assign tmo_hit    = (cnt_q == CW'(TMO - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (en) begin
      unique case (state_q)
        IDLE:    if (req_0 | req_1) state_d = SETUP;
        SETUP:   state_d = RUN;
        RUN:     if (core_eoc || tmo_hit) state_d = DONE;
        DONE:    if (rready_own) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    cnt_d    = cnt_q;
    last_d   = last_q;
    owner_d  = owner_q;
    acc_d    = acc_q;
    rvalid_d = rvalid_q;
    rerr_d   = rerr_q;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    cm_d     = cm_q;
    cn_d     = cn_q;
    ce_d     = ce_q;
    if (en) begin
      acc_d = 2'b00;
      unique case (state_q)
        IDLE: begin
          if (req_0 | req_1) begin
            owner_d    = win;
            acc_d[win] = 1'b1;
            cm_d       = win ? m_1 : m_0;
            cn_d       = win ? n_1 : n_0;
            ce_d       = win ? e_1 : e_0;
          end
        end
        SETUP: cnt_d = '0;
        RUN: begin
          // End-of-computation wins over a simultaneous timeout.
          if (core_eoc || tmo_hit) begin
            rvalid_d[owner_q] = 1'b1;
            rerr_d[owner_q]   = ~core_eoc;
            if (owner_q) rdata1_d = core_eoc ? core_res : '0;
            else         rdata0_d = core_eoc ? core_res : '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        DONE: begin
          if (rready_own) begin
            rvalid_d[owner_q] = 1'b0;
            last_d            = owner_q;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q    <= '0;
      last_q   <= 1'b1;
      owner_q  <= 1'b0;
      acc_q    <= '0;
      rvalid_q <= '0;
      rerr_q   <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
      cm_q     <= '0;
      cn_q     <= '0;
      ce_q     <= '0;
      rstb_q   <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      last_q   <= last_d;
      owner_q  <= owner_d;
      acc_q    <= acc_d;
      rvalid_q <= rvalid_d;
      rerr_q   <= rerr_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
      cm_q     <= cm_d;
      cn_q     <= cn_d;
      ce_q     <= ce_d;
      rstb_q   <= 1'b1;
    end
  end

  // Core controls follow the state directly so a low enable stops the core at once.
  assign core_en   = en & (state_q == RUN);
  assign core_rstb = rstb_q & (state_q != SETUP);
  assign busy      = (state_q != IDLE);
  assign owner     = owner_q;
  assign acc_0     = acc_q[0];
  assign acc_1     = acc_q[1];
  assign rvalid_0  = rvalid_q[0];
  assign rvalid_1  = rvalid_q[1];
  assign rerr_0    = rerr_q[0];
  assign rerr_1    = rerr_q[1];
  assign rdata_0   = rdata0_q;
  assign rdata_1   = rdata1_q;
  assign core_m    = cm_q;
  assign core_n    = cn_q;
  assign core_e    = ce_q;

endmodule
